nios_noc_bridge: RTL and testbench

- Hardware end of the Nios send/recv PIO mailbox.
- Turns Nios writes on the send_addr/send_data PIOs into packets on the network injection port, through a TX FIFO.
- Delivers packets from the network ejection port into an RX FIFO and presents them one at a time on the recv_addr/recv_data PIO inputs.
- PIOs carry no handshake, so both directions use toggle bits. Same clock domain as the Nios; no synchronisers.

---
 rtl/nios_noc_pkg.sv | 26 ++
 rtl/nios_noc_bridge_if.sv | 24 ++
 rtl/nios_noc_bridge_sync_fifo.sv | 50 +++++
 rtl/nios_noc_bridge.sv | 159 +++++++++++++++
 tb/tb_nios_noc_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_noc_pkg.sv
// Shared constants and types for the Nios PIO mailbox <-> NoC bridge.
// Holds PIO bit positions, default port width, packet and RX state types.
package nios_noc_pkg;

   // send_addr (Nios -> bridge) control bits
   localparam int TX_REQ_BIT   = 7;
   localparam int RX_ACK_BIT   = 6;

   // recv_addr (bridge -> Nios) status bits
   localparam int RX_VALID_BIT = 7;
   localparam int TX_FULL_BIT  = 6;
   localparam int RX_OVF_BIT   = 5;

   localparam int NOC_PORT_W   = 4;

   typedef struct packed {
      logic [NOC_PORT_W-1:0] port;
      logic [31:0]           data;
   } pkt_t;

   typedef enum logic [0:0] {
      RX_IDLE     = 1'b0,
      RX_WAIT_ACK = 1'b1
   } rx_state_e;

endpackage

// File: rtl/nios_noc_bridge_if.sv
// Network injection/ejection port bundle of the bridge.
// master: bridge side (drives net_tx_*, net_rx_ready); slave: network side.
interface nios_noc_bridge_if #(
   parameter int PORT_W = 4
);
   logic              net_tx_valid;
   logic [PORT_W-1:0] net_tx_dest;
   logic [31:0]       net_tx_data;
   logic              net_tx_ready;
   logic              net_rx_valid;
   logic [PORT_W-1:0] net_rx_src;
   logic [31:0]       net_rx_data;
   logic              net_rx_ready;

   modport master (
      output net_tx_valid, net_tx_dest, net_tx_data, net_rx_ready,
      input  net_tx_ready, net_rx_valid, net_rx_src, net_rx_data
   );

   modport slave (
      input  net_tx_valid, net_tx_dest, net_tx_data, net_rx_ready,
      output net_tx_ready, net_rx_valid, net_rx_src, net_rx_data
   );
endinterface

// File: rtl/nios_noc_bridge_sync_fifo.sv
// Single-clock show-ahead FIFO with extra-MSB pointers.
// Ports: push_i/din_i write, pop_i/dout_o read head, full_o/empty_o/count_o status.
module sync_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic         do_push, do_pop;

   // Same index with differing MSB means the writer lapped the reader.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign count_o = wr_q - rd_q;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
   assign rd_d = do_pop ? rd_q + 1'b1 : rd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end
endmodule

// File: rtl/nios_noc_bridge.sv
// Nios send/recv PIO mailbox to NoC injection/ejection bridge, toggle handshakes.
// Ports: clk, reset_n, send_addr/send_data (PIO in), recv_addr/recv_data (PIO out), net (NoC).
module nios_noc_bridge
   import nios_noc_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int PORT_W     = NOC_PORT_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         send_addr,
   input  logic [31:0]        send_data,
   output logic [7:0]         recv_addr,
   output logic [31:0]        recv_data,
   nios_noc_bridge_if.master  net
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = PORT_W + 32;

   localparam logic [0:0] IDLE     = RX_IDLE;
   localparam logic [0:0] WAIT_ACK = RX_WAIT_ACK;

   logic [7:0]        s_addr_q;
   logic [31:0]       s_data_q;
   logic              tx_hist_q;
   logic              ack_hist_q;
   logic              tx_full_q;
   logic              alive_q;
   logic [0:0]        rx_state_q, rx_state_d;
   logic              rv_q, rv_d;
   logic [PORT_W-1:0] pres_src_q, pres_src_d;
   logic [31:0]       pres_data_q, pres_data_d;
   logic              ovf_q;
   logic [7:0]        ovf_cnt_q;

   logic              tx_evt, tx_push, tx_pop;
   logic              tx_full, tx_empty;
   logic [CW-1:0]     tx_cnt;
   logic [PW-1:0]     tx_din, tx_dout;

   logic              ack_evt, rx_push, rx_pop;
   logic              rx_full, rx_empty, ovf_hit;
   logic [CW-1:0]     rx_cnt;
   logic [PW-1:0]     rx_din, rx_dout;

   logic              unused_addr;

   assign unused_addr = ^s_addr_q[5:4];

   // TX: a flip of the request bit enqueues dest+payload captured with it.
   assign tx_evt  = s_addr_q[TX_REQ_BIT] ^ tx_hist_q;
   assign tx_push = tx_evt && !tx_full;
   assign tx_din  = {PORT_W'(s_addr_q[3:0]), s_data_q};
   assign tx_pop  = net.net_tx_valid && net.net_tx_ready;

   sync_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (tx_push),
      .pop_i   (tx_pop),
      .din_i   (tx_din),
      .dout_o  (tx_dout),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_cnt)
   );

   assign net.net_tx_valid = !tx_empty;
   assign net.net_tx_dest  = tx_empty ? '0 : tx_dout[PW-1:32];
   assign net.net_tx_data  = tx_empty ? '0 : tx_dout[31:0];

   // RX: ready is held low during reset and until the first clock after it.
   assign net.net_rx_ready = alive_q && !rx_full;
   assign rx_push = net.net_rx_valid && net.net_rx_ready;
   assign rx_din  = {net.net_rx_src, net.net_rx_data};
   assign ack_evt = s_addr_q[RX_ACK_BIT] ^ ack_hist_q;
   assign ovf_hit = net.net_rx_valid && (rx_cnt == CW'(FIFO_DEPTH));

   sync_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push_i  (rx_push),
      .pop_i   (rx_pop),
      .din_i   (rx_din),
      .dout_o  (rx_dout),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_cnt)
   );

   // Payload and valid toggle load together, so data is never stale.
   always_comb begin
      rx_state_d  = rx_state_q;
      rv_d        = rv_q;
      pres_src_d  = pres_src_q;
      pres_data_d = pres_data_q;
      rx_pop      = 1'b0;
      unique case (rx_state_q)
         IDLE: begin
            if (!rx_empty) begin
               rx_pop      = 1'b1;
               pres_src_d  = rx_dout[PW-1:32];
               pres_data_d = rx_dout[31:0];
               rv_d        = ~rv_q;
               rx_state_d  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_evt) rx_state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_addr_q    <= '0;
         s_data_q    <= '0;
         tx_hist_q   <= 1'b0;
         ack_hist_q  <= 1'b0;
         tx_full_q   <= 1'b0;
         alive_q     <= 1'b0;
         rx_state_q  <= IDLE;
         rv_q        <= 1'b0;
         pres_src_q  <= '0;
         pres_data_q <= '0;
         ovf_q       <= 1'b0;
         ovf_cnt_q   <= '0;
      end else begin
         s_addr_q    <= send_addr;
         s_data_q    <= send_data;
         tx_hist_q   <= s_addr_q[TX_REQ_BIT];
         ack_hist_q  <= s_addr_q[RX_ACK_BIT];
         tx_full_q   <= (tx_cnt == CW'(FIFO_DEPTH));
         alive_q     <= 1'b1;
         rx_state_q  <= rx_state_d;
         rv_q        <= rv_d;
         pres_src_q  <= pres_src_d;
         pres_data_q <= pres_data_d;
         // Sticky after the 256th consecutive blocked cycle.
         if (!ovf_hit) begin
            ovf_cnt_q <= '0;
         end else if (ovf_cnt_q == 8'hFF) begin
            ovf_q <= 1'b1;
         end else begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      recv_addr               = '0;
      recv_addr[RX_VALID_BIT] = rv_q;
      recv_addr[TX_FULL_BIT]  = tx_full_q;
      recv_addr[RX_OVF_BIT]   = ovf_q;
      recv_addr[3:0]          = 4'(pres_src_q);
   end

   assign recv_data = pres_data_q;
endmodule

// File: tb/tb_nios_noc_bridge.sv
// Scoreboard bench for nios_noc_bridge: directed cases then a random mix.
// Expected packets queue on issue; monitors pop and compare on DUT outputs.
module tb_nios_noc_bridge;
   import nios_noc_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [7:0]  send_addr;
   logic [31:0] send_data;
   logic [7:0]  recv_addr;
   logic [31:0] recv_data;

   logic        tx_tog;
   logic        ack_tog;
   logic [3:0]  dest;
   logic        rdy_cfg, rnd_rdy, rnd_mode;
   logic        rxv;
   logic [3:0]  rx_src;
   logic [31:0] rx_data;
   logic        auto_ack;
   int          acks_req, acks_done;

   int vectors;
   int miscompares;

   pkt_t txq[$];
   pkt_t rxq[$];

   nios_noc_bridge_if #(.PORT_W(4)) nif ();

   assign send_addr        = {tx_tog, ack_tog, 2'b00, dest};
   assign nif.net_tx_ready = rnd_mode ? rnd_rdy : rdy_cfg;
   assign nif.net_rx_valid = rxv;
   assign nif.net_rx_src   = rx_src;
   assign nif.net_rx_data  = rx_data;

   nios_noc_bridge #(.FIFO_DEPTH(4), .PORT_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .send_addr (send_addr),
      .send_data (send_data),
      .recv_addr (recv_addr),
      .recv_data (recv_data),
      .net       (nif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_send(input logic [3:0] d, input logic [31:0] v,
                          input bit accept);
      pkt_t p;
      dest      = d;
      send_data = v;
      tx_tog    = ~tx_tog;
      p.port    = d;
      p.data    = v;
      if (accept) txq.push_back(p);
   endtask

   task automatic rx_send(input logic [3:0] s, input logic [31:0] d,
                          output bit rdy_first);
      pkt_t p;
      int n;
      rxv     = 1'b1;
      rx_src  = s;
      rx_data = d;
      n = 0;
      @(negedge clk);
      rdy_first = nif.net_rx_ready;
      while (!nif.net_rx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!nif.net_rx_ready) begin
         chk("rx_inject_timeout", 64'(nif.net_rx_ready), 64'd1);
      end else begin
         p.port = s;
         p.data = d;
         rxq.push_back(p);
      end
      @(posedge clk);
      #1;
      rxv = 1'b0;
   endtask

   // TX monitor: each accepted network packet must match the queue head.
   initial begin
      pkt_t e;
      forever begin
         @(negedge clk);
         if (reset_n && nif.net_tx_valid && nif.net_tx_ready) begin
            if (txq.size() == 0) begin
               chk("tx_unexpected", 64'(nif.net_tx_data), 64'hFFFF_FFFF_FFFF);
            end else begin
               e = txq.pop_front();
               chk("tx_dest", 64'(nif.net_tx_dest), 64'(e.port));
               chk("tx_data", 64'(nif.net_tx_data), 64'(e.data));
            end
         end
      end
   end

   // RX monitor: every recv toggle presents the next expected packet.
   initial begin
      pkt_t e;
      logic last_rv;
      last_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            last_rv = 1'b0;
         end else if (recv_addr[7] != last_rv) begin
            last_rv = recv_addr[7];
            if (rxq.size() == 0) begin
               chk("rx_unexpected", 64'(recv_data), 64'hFFFF_FFFF_FFFF);
            end else begin
               e = rxq.pop_front();
               chk("rx_src", 64'(recv_addr[3:0]), 64'(e.port));
               chk("rx_data", 64'(recv_data), 64'(e.data));
            end
         end
      end
   end

   // Nios-side ack driver: explicit requests, or random delay in auto mode.
   initial begin
      ack_tog   = 1'b0;
      acks_done = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset_n) begin
            ack_tog   = 1'b0;
            acks_done = acks_req;
         end else if (acks_done != acks_req) begin
            ack_tog = ~ack_tog;
            acks_done++;
         end else if (auto_ack && recv_addr[7] != ack_tog &&
                      $urandom_range(0, 2) == 0) begin
            ack_tog = ~ack_tog;
         end
      end
   end

   initial begin
      rnd_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rnd_rdy = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r;
      vectors     = 0;
      miscompares = 0;
      tx_tog      = 1'b0;
      dest        = 4'h0;
      send_data   = '0;
      rdy_cfg     = 1'b0;
      rnd_mode    = 1'b0;
      rxv         = 1'b0;
      rx_src      = '0;
      rx_data     = '0;
      auto_ack    = 1'b0;
      acks_req    = 0;
      reset_n     = 1'b1;
      #1 reset_n  = 1'b0;

      tick(3);
      chk("rst_recv_addr", 64'(recv_addr), 64'd0);
      chk("rst_recv_data", 64'(recv_data), 64'd0);
      chk("rst_tx_valid", 64'(nif.net_tx_valid), 64'd0);
      chk("rst_rx_ready", 64'(nif.net_rx_ready), 64'd0);
      reset_n = 1'b1;
      tick(2);
      chk("rx_ready_up", 64'(nif.net_rx_ready), 64'd1);

      // Single send and its latency window
      rdy_cfg = 1'b1;
      tx_send(4'd5, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk);
      chk("lat_cycle1", 64'(nif.net_tx_valid), 64'd0);
      @(negedge clk);
      chk("lat_cycle2", 64'(nif.net_tx_valid), 64'd0);
      @(negedge clk);
      chk("lat_cycle3", 64'(nif.net_tx_valid), 64'd1);
      @(negedge clk);
      chk("single_only", 64'(nif.net_tx_valid), 64'd0);
      tick(2);

      // TX overflow: fifth request dropped
      rdy_cfg = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tx_send(4'($urandom_range(0, 15)), 32'(i), txq.size() < 4);
         tick(3);
         if (i == 3) chk("tx_full_early", 64'(recv_addr[6]), 64'd0);
      end
      tick(2);
      chk("tx_full_set", 64'(recv_addr[6]), 64'd1);
      chk("tx_held", 64'(txq.size()), 64'd4);
      rdy_cfg = 1'b1;
      tick(10);
      chk("tx_drained", 64'(txq.size()), 64'd0);
      chk("tx_full_clr", 64'(recv_addr[6]), 64'd0);

      // Receive and ack
      rx_send(4'd3, 32'h1234_5678, r);
      tick(4);
      chk("rx_toggle", 64'(recv_addr[7]), 64'd1);
      chk("rx_src_pin", 64'(recv_addr[3:0]), 64'd3);
      chk("rx_data_pin", 64'(recv_data), 64'h1234_5678);
      tick(10);
      chk("rx_hold", 64'(recv_addr[7]), 64'd1);
      acks_req++;
      tick(5);
      chk("rx_no_repeat", 64'(recv_addr[7]), 64'd1);

      // Back-to-back RX with slow Nios
      for (int i = 0; i < 3; i++) begin
         rx_send(4'(4'hA + i), 32'hA000_0000 + 32'(i), r);
         chk("b2b_ready", 64'(r), 64'd1);
      end
      tick(4);
      chk("b2b_pend", 64'(rxq.size()), 64'd2);
      for (int k = 1; k <= 3; k++) begin
         acks_req++;
         tick(6);
         chk("b2b_after_ack", 64'(rxq.size()), 64'(k < 2 ? 2 - k : 0));
      end

      // RX full and deadlock indicator
      for (int i = 0; i < 5; i++) rx_send(4'(i), $urandom, r);
      tick(3);
      chk("rxfull_ready", 64'(nif.net_rx_ready), 64'd0);
      chk("rxfull_pend", 64'(rxq.size()), 64'd4);
      rxv     = 1'b1;
      rx_src  = 4'hF;
      rx_data = 32'hBAD0_BAD0;
      tick(100);
      chk("ovf_early", 64'(recv_addr[5]), 64'd0);
      tick(200);
      chk("ovf_set", 64'(recv_addr[5]), 64'd1);
      rxv = 1'b0;
      for (int k = 0; k < 5; k++) begin
         acks_req++;
         tick(6);
      end
      chk("rxfull_drain", 64'(rxq.size()), 64'd0);
      chk("ovf_sticky", 64'(recv_addr[5]), 64'd1);

      // Async reset with both FIFOs partly full
      rdy_cfg = 1'b0;
      tx_send(4'd1, 32'h1111_1111, 1'b1);
      tick(2);
      tx_send(4'd2, 32'h2222_2222, 1'b1);
      for (int i = 0; i < 3; i++) rx_send(4'(i + 1), $urandom, r);
      tick(4);
      chk("pre_rst_valid", 64'(nif.net_tx_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_recv_addr", 64'(recv_addr), 64'd0);
      chk("arst_recv_data", 64'(recv_data), 64'd0);
      chk("arst_tx_valid", 64'(nif.net_tx_valid), 64'd0);
      chk("arst_tx_data", 64'(nif.net_tx_data), 64'd0);
      chk("arst_rx_ready", 64'(nif.net_rx_ready), 64'd0);
      txq.delete();
      rxq.delete();
      tx_tog    = 1'b0;
      dest      = 4'h0;
      send_data = '0;
      tick(2);
      reset_n = 1'b1;
      tick(2);
      rdy_cfg = 1'b1;
      tx_send(4'd9, 32'hCAFE_F00D, 1'b1);
      tick(6);
      chk("post_rst_tx", 64'(txq.size()), 64'd0);
      rx_send(4'd7, 32'h7777_0007, r);
      tick(4);
      chk("post_rst_rx", 64'(recv_addr[7]), 64'd1);
      acks_req++;
      tick(5);

      // Random mix with auto-acking Nios and random network backpressure
      rnd_mode = 1'b1;
      auto_ack = 1'b1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               tick($urandom_range(1, 3));
               if (txq.size() < 4)
                  tx_send(4'($urandom_range(0, 15)), $urandom, 1'b1);
            end
         end
         begin
            bit rr;
            for (int i = 0; i < 30; i++) begin
               tick($urandom_range(0, 3));
               rx_send(4'($urandom_range(0, 15)), $urandom, rr);
            end
         end
      join
      begin
         int n;
         n = 0;
         while ((txq.size() != 0 || rxq.size() != 0) && n < 1000) begin
            tick(1);
            n++;
         end
      end
      chk("rand_tx_done", 64'(txq.size()), 64'd0);
      chk("rand_rx_done", 64'(rxq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
